// File: rtl/free_list_banked_pkg.sv
// free_list_banked_pkg: shared free-list constants and types (default 128 PRs, 4 banks, 32 reserved)
package free_list_banked_pkg;
    localparam int PR_COUNT                      = 128;
    localparam int AR_COUNT                      = 32;
    localparam int FREE_LIST_BANK_COUNT          = 4;
    localparam int LOG_PR_COUNT                  = $clog2(PR_COUNT);
    localparam int LOG_FREE_LIST_BANK_COUNT      = $clog2(FREE_LIST_BANK_COUNT);
    localparam int FREE_LIST_LENGTH_PER_BANK     = PR_COUNT / FREE_LIST_BANK_COUNT;
    localparam int LOG_FREE_LIST_LENGTH_PER_BANK = $clog2(FREE_LIST_LENGTH_PER_BANK);
    localparam int FREE_LIST_RESERVED_PER_BANK   = AR_COUNT / FREE_LIST_BANK_COUNT;
    localparam int FREE_LIST_LOWER_THRESHOLD     = 8;
    localparam int FREE_LIST_UPPER_THRESHOLD     = 24;
    typedef logic [LOG_PR_COUNT-1:0] pr_id_t;
    typedef logic [LOG_FREE_LIST_LENGTH_PER_BANK:0] free_list_count_t;
endpackage

// File: rtl/free_list_bank.sv
// free_list_bank: one circular FIFO bank of free PR ids with optional empty-bank bypass
// Ports: CLK, RST (sync, active-high); enq_valid/enq_pr push a freed PR; deq_req pops the head;
// deq_valid/deq_pr expose the head; count is occupancy; overflow pulses on an enqueue into a full bank.
// FREE_LIST_BYPASS_EN: an empty bank forwards enq_pr straight to deq_pr in the same cycle.
module free_list_bank
    import free_list_banked_pkg::*;
#(
    parameter int LEN        = 32,
    parameter int BANK_IDX   = 0,
    parameter int RPB        = 8,
    parameter int BANK_COUNT = 4,
    parameter int PR_W       = 7
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   enq_valid,
    input  logic [PR_W-1:0]        enq_pr,
    input  logic                   deq_req,
    output logic                   deq_valid,
    output logic [PR_W-1:0]        deq_pr,
    output logic [$clog2(LEN):0]   count,
    output logic                   overflow
);
    localparam int LOG_LEN = $clog2(LEN);
    localparam int CW      = LOG_LEN + 1;
    localparam logic [CW-1:0] FULL = CW'(LEN);

    logic [PR_W-1:0]    mem [LEN];
    logic [LOG_LEN-1:0] head;
    logic [LOG_LEN-1:0] tail;
    logic               bypass;
    logic               deq_fire;
    logic               enq_acc;

`ifdef FREE_LIST_BYPASS_EN
    assign bypass = (count == '0) && enq_valid;
`else
    assign bypass = 1'b0;
`endif

    assign deq_valid = (count != '0) || bypass;
    assign deq_pr    = bypass ? enq_pr : mem[head];
    assign deq_fire  = deq_req && (count != '0);
    // A bypassed PR consumed in the same cycle never touches storage; a pop frees a slot for the push.
    assign enq_acc   = enq_valid && !(bypass && deq_req) && ((count != FULL) || deq_fire);
    assign overflow  = enq_valid && (count == FULL) && !deq_fire;

    always_ff @(posedge CLK) begin
        if (RST) begin
            head  <= '0;
            tail  <= LOG_LEN'(LEN - RPB);
            count <= CW'(LEN - RPB);
            for (int i = 0; i < LEN; i++)
                mem[i] <= (i < LEN - RPB) ? PR_W'((RPB + i) * BANK_COUNT + BANK_IDX) : '0;
        end else begin
            if (deq_fire)
                head <= head + 1'b1;
            if (enq_acc) begin
                mem[tail] <= enq_pr;
                tail      <= tail + 1'b1;
            end
            count <= count + CW'(enq_acc) - CW'(deq_fire);
        end
    end
endmodule

// File: rtl/free_list_banked.sv
// free_list_banked: banked rename free list with occupancy flags, preferred-bank hint and sticky error
// Ports: CLK, RST (sync, active-high); per-bank enq_valid/enq_pr, deq_req, deq_valid/deq_pr,
// count, low/high threshold flags; preferred_bank = fullest bank (lowest index on ties);
// err_sticky = overflow or wrong-bank enqueue since reset.
// FREE_LIST_BYPASS_EN (passed to every bank): empty banks forward enqueued PRs combinationally.
module free_list_banked #(
    parameter int PR_COUNT        = free_list_banked_pkg::PR_COUNT,
    parameter int BANK_COUNT      = free_list_banked_pkg::FREE_LIST_BANK_COUNT,
    parameter int RESERVED_COUNT  = free_list_banked_pkg::AR_COUNT,
    parameter int LOWER_THRESHOLD = free_list_banked_pkg::FREE_LIST_LOWER_THRESHOLD,
    parameter int UPPER_THRESHOLD = free_list_banked_pkg::FREE_LIST_UPPER_THRESHOLD
) (
    input  logic                                                  CLK,
    input  logic                                                  RST,
    input  logic [BANK_COUNT-1:0]                                 enq_valid_by_bank,
    input  logic [BANK_COUNT-1:0][$clog2(PR_COUNT)-1:0]           enq_pr_by_bank,
    input  logic [BANK_COUNT-1:0]                                 deq_req_by_bank,
    output logic [BANK_COUNT-1:0]                                 deq_valid_by_bank,
    output logic [BANK_COUNT-1:0][$clog2(PR_COUNT)-1:0]           deq_pr_by_bank,
    output logic [BANK_COUNT-1:0][$clog2(PR_COUNT/BANK_COUNT):0]  count_by_bank,
    output logic [BANK_COUNT-1:0]                                 low_by_bank,
    output logic [BANK_COUNT-1:0]                                 high_by_bank,
    output logic [$clog2(BANK_COUNT)-1:0]                         preferred_bank,
    output logic                                                  err_sticky
);
    import free_list_banked_pkg::*;

    localparam int PR_W   = $clog2(PR_COUNT);
    localparam int LEN    = PR_COUNT / BANK_COUNT;
    localparam int CW     = $clog2(LEN) + 1;
    localparam int RPB    = RESERVED_COUNT / BANK_COUNT;
    localparam int BANK_W = $clog2(BANK_COUNT);

    logic [BANK_COUNT-1:0] overflow;
    logic [BANK_COUNT-1:0] mismatch;
    logic [CW-1:0]         best;

    for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
        free_list_bank #(
            .LEN(LEN),
            .BANK_IDX(b),
            .RPB(RPB),
            .BANK_COUNT(BANK_COUNT),
            .PR_W(PR_W)
        ) u_bank (
            .CLK(CLK),
            .RST(RST),
            .enq_valid(enq_valid_by_bank[b]),
            .enq_pr(enq_pr_by_bank[b]),
            .deq_req(deq_req_by_bank[b]),
            .deq_valid(deq_valid_by_bank[b]),
            .deq_pr(deq_pr_by_bank[b]),
            .count(count_by_bank[b]),
            .overflow(overflow[b])
        );
        // Bank of a PR is its low bits since BANK_COUNT is a power of two.
        assign mismatch[b]     = enq_valid_by_bank[b] && (enq_pr_by_bank[b][BANK_W-1:0] != BANK_W'(b));
        assign low_by_bank[b]  = count_by_bank[b] < CW'(LOWER_THRESHOLD);
        assign high_by_bank[b] = count_by_bank[b] > CW'(UPPER_THRESHOLD);
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        preferred_bank = '0;
        best           = count_by_bank[0];
        for (int i = 1; i < BANK_COUNT; i++)
            if (count_by_bank[i] > best) begin
                best           = count_by_bank[i];
                preferred_bank = BANK_W'(i);
            end
    end

    always_ff @(posedge CLK) begin
        if (RST)
            err_sticky <= 1'b0;
        else
            err_sticky <= err_sticky || (|overflow) || (|mismatch);
    end
endmodule
